// File: rtl/lm07_pkg.sv
// Shared LM07 constants and responder state encoding.
package lm07_pkg;
    localparam int LM07_TEMP_W    = 13;
    localparam int LM07_TAIL_BITS = 3;
    localparam int LM07_FRAME_W   = LM07_TEMP_W + LM07_TAIL_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        TAIL
    } lm07_state_t;
endpackage

// File: rtl/lm07_responder_if.sv
// LM07 serial bus: master drives CS/SCK, responder drives SIO/SIO_OE.
interface lm07_responder_if;
    logic CS;
    logic SCK;
    logic SIO;
    logic SIO_OE;

    modport master (output CS, output SCK, input SIO, input SIO_OE);
    modport slave  (input CS, input SCK, output SIO, output SIO_OE);
endinterface

// File: rtl/lm07_responder_sync_edge.sv
// Two-flop synchronizer with registered previous value and edge pulses.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
endmodule

// File: rtl/lm07_responder.sv
// LM07 temperature sensor emulator: shifts {temp, tail ones} out MSB first per CS frame.
module lm07_responder
    import lm07_pkg::*;
#(
    parameter int                TEMP_W     = LM07_TEMP_W,
    parameter int                TAIL_BITS  = LM07_TAIL_BITS,
    parameter logic [TEMP_W-1:0] RESET_TEMP = '0
) (
    input  logic              SYSCLK,
    input  logic              RST,
    lm07_responder_if.slave   spi,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic              temp_wr,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort
);
    localparam int FRAME_W = TEMP_W + TAIL_BITS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    lm07_state_t state, state_n;

    logic               cs_rise, cs_fall, sck_fall, sck_rise_unused;
    logic [FRAME_W-1:0] frame_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TEMP_W-1:0]  shadow, pending;
    logic               pend_vld;
    logic               sio, sio_oe;
    logic               load, shift, tail_fall, fin, done_n, abort_n;
    logic               active;

    // CS idles high so reset must not look like a falling edge.
    sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk (SYSCLK),
        .rst (RST),
        .din (spi.CS),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk (SYSCLK),
        .rst (RST),
        .din (spi.SCK),
        .rise(sck_rise_unused),
        .fall(sck_fall)
    );

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        shift     = 1'b0;
        tail_fall = 1'b0;
        fin       = 1'b0;
        done_n    = 1'b0;
        abort_n   = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_n = LOAD;
            LOAD: begin
                if (cs_rise) begin
                    abort_n = 1'b1;
                    fin     = 1'b1;
                    state_n = IDLE;
                end else begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_n = 1'b1;
                    fin     = 1'b1;
                    state_n = IDLE;
                end else if (sck_fall) begin
                    shift = 1'b1;
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) state_n = TAIL;
                end
            end
            TAIL: begin
                if (cs_rise) begin
                    done_n  = 1'b1;
                    fin     = 1'b1;
                    state_n = IDLE;
                end else if (sck_fall) begin
                    tail_fall = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign active = (state != IDLE);

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            frame_sr    <= '0;
            bit_cnt     <= '0;
            sio         <= 1'b0;
            sio_oe      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= done_n;
            frame_abort <= abort_n;
            if (load) begin
                frame_sr <= {shadow, {TAIL_BITS{1'b1}}};
                sio      <= shadow[TEMP_W-1];
                sio_oe   <= 1'b1;
                busy     <= 1'b1;
                bit_cnt  <= CNT_W'(1);
            end else if (shift) begin
                frame_sr <= frame_sr << 1;
                sio      <= frame_sr[FRAME_W-2];
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end else if (tail_fall) begin
                sio <= 1'b0;
            end else if (fin) begin
                sio    <= 1'b0;
                sio_oe <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

    // A write landing on the frame-release edge is newer than any pending value.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            shadow   <= RESET_TEMP;
            pending  <= RESET_TEMP;
            pend_vld <= 1'b0;
        end else begin
            if (temp_wr && active) begin
                pending  <= temp_in;
                pend_vld <= 1'b1;
            end
            if (fin) begin
                if (temp_wr)       shadow <= temp_in;
                else if (pend_vld) shadow <= pending;
                pend_vld <= 1'b0;
            end else if (temp_wr && !active) begin
                shadow <= temp_in;
            end
        end
    end

    assign spi.SIO    = sio;
    assign spi.SIO_OE = sio_oe;
endmodule

// File: tb/tb_lm07_responder.sv
// Bench for lm07_responder: SPI master model reading frames against a shadow/pending reference.
module tb_lm07_responder;
    logic        SYSCLK = 1'b0;
    logic        RST;
    logic [12:0] temp_in;
    logic        temp_wr;
    logic        busy, frame_done, frame_abort;

    lm07_responder_if bus ();

    lm07_responder #(
        .TEMP_W    (13),
        .TAIL_BITS (3),
        .RESET_TEMP(13'h0000)
    ) dut (
        .SYSCLK     (SYSCLK),
        .RST        (RST),
        .spi        (bus),
        .temp_in    (temp_in),
        .temp_wr    (temp_wr),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_abort(frame_abort)
    );

    always #10 SYSCLK = ~SYSCLK;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    always @(posedge SYSCLK) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    // Reference: visible temperature, a pending slot, and whether a frame is open.
    logic [12:0] m_shadow;
    logic [12:0] m_pend;
    bit          m_pvld;
    bit          m_inframe;
    logic [15:0] exp_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic write_temp(input logic [12:0] v);
        temp_in = v;
        temp_wr = 1'b1;
        cyc(1);
        temp_wr = 1'b0;
        if (m_inframe) begin
            m_pend = v;
            m_pvld = 1'b1;
        end else begin
            m_shadow = v;
        end
    endtask

    task automatic start_frame(input string tag);
        exp_word  = {m_shadow, 3'b111};
        bus.CS    = 1'b0;
        m_inframe = 1'b1;
        cyc(3);
        check({tag, "_oe_early"}, {31'b0, bus.SIO_OE}, 32'd0);
        cyc(1);
        check({tag, "_first_bit"}, {29'b0, busy, bus.SIO_OE, bus.SIO}, {29'b0, 2'b11, exp_word[15]});
        cyc(21);
    endtask

    task automatic clock_bits(input int n, inout logic [31:0] w);
        for (int i = 0; i < n; i++) begin
            w = {w[30:0], bus.SIO};
            bus.SCK = 1'b1;
            cyc(25);
            bus.SCK = 1'b0;
            cyc(25);
        end
    endtask

    task automatic end_frame(input string tag);
        cyc(10);
        bus.CS = 1'b1;
        cyc(5);
        m_inframe = 1'b0;
        if (m_pvld) begin
            m_shadow = m_pend;
            m_pvld   = 1'b0;
        end
        check({tag, "_idle"}, {29'b0, busy, bus.SIO_OE, bus.SIO}, 32'd0);
    endtask

    task automatic full_frame(input string tag);
        logic [31:0] w;
        int d0;
        d0 = done_cnt;
        w  = '0;
        start_frame(tag);
        clock_bits(16, w);
        end_frame(tag);
        check({tag, "_word"}, w, {16'b0, exp_word});
        check({tag, "_done"}, done_cnt - d0, 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [12:0] v;
        int d0, a0, k;

        RST = 1'b1; bus.CS = 1'b1; bus.SCK = 1'b0; temp_in = '0; temp_wr = 1'b0;
        m_shadow = 13'h0000; m_pend = 13'h0000; m_pvld = 0; m_inframe = 0;
        cyc(3);
        check("reset_out", {27'b0, bus.SIO, bus.SIO_OE, busy, frame_done, frame_abort}, 32'd0);
        RST = 1'b0;
        cyc(3);

        // +25 degC and -25 degC frames with literal expected words
        write_temp(13'h0190);
        full_frame("t1");
        check("t1_literal", {16'b0, exp_word}, 32'h0C87);
        write_temp(13'h1E70);
        full_frame("t2");
        check("t2_literal", {16'b0, exp_word}, 32'hF387);

        // mid-frame write is deferred to the next frame
        write_temp(13'h0190);
        w = '0;
        start_frame("t3a");
        clock_bits(5, w);
        write_temp(13'h0020);
        clock_bits(11, w);
        end_frame("t3a");
        check("t3a_word", w, 32'h0C87);
        full_frame("t3b");
        check("t3b_literal", {16'b0, exp_word}, 32'h0107);

        // abort after 5 SCK
        write_temp(13'h0AB5);
        w = '0; d0 = done_cnt; a0 = abort_cnt;
        start_frame("t4");
        clock_bits(5, w);
        check("t4_bits", w, {27'b0, exp_word[15:11]});
        bus.CS = 1'b1;
        cyc(4);
        check("t4_idle", {30'b0, busy, bus.SIO_OE}, 32'd0);
        cyc(2);
        m_inframe = 0;
        check("t4_abort", abort_cnt - a0, 32'd1);
        check("t4_nodone", done_cnt - d0, 32'd0);

        // 20 SCK in one window: trailing bits read zero
        write_temp(13'h1FFF);
        w = '0; d0 = done_cnt;
        start_frame("t5");
        clock_bits(20, w);
        end_frame("t5");
        check("t5_word", w, {12'b0, exp_word, 4'b0000});
        check("t5_done", done_cnt - d0, 32'd1);

        // write in the LOAD cycle goes pending; frame uses old value
        exp_word = {m_shadow, 3'b111};
        w = '0;
        bus.CS = 1'b0;
        m_inframe = 1;
        cyc(3);
        write_temp(13'h0155);
        cyc(21);
        clock_bits(16, w);
        end_frame("tload");
        check("tload_word", w, {16'b0, exp_word});
        full_frame("tload_next");
        check("tload_next_lit", {16'b0, exp_word}, {16'b0, 13'h0155, 3'b111});

        // reset mid-frame drops the pending write
        write_temp(13'h0777);
        w = '0; d0 = done_cnt; a0 = abort_cnt;
        start_frame("t6");
        clock_bits(4, w);
        write_temp(13'h0333);
        clock_bits(4, w);
        RST = 1'b1;
        #1;
        check("t6_reset", {27'b0, bus.SIO, bus.SIO_OE, busy, frame_done, frame_abort}, 32'd0);
        m_shadow = 13'h0000; m_pvld = 0; m_inframe = 0;
        bus.CS = 1'b1;
        cyc(3);
        RST = 1'b0;
        cyc(5);
        check("t6_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
        full_frame("t6_next");
        check("t6_next_lit", {16'b0, exp_word}, 32'h0007);

        // randomized writes before and during frames
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(1, 0) == 1) write_temp(13'($urandom));
            v = 13'($urandom);
            k = int'($urandom_range(15, 1));
            w = '0;
            start_frame("rnd");
            clock_bits(k, w);
            if ($urandom_range(1, 0) == 1) write_temp(v);
            clock_bits(16 - k, w);
            end_frame("rnd");
            check("rnd_word", w, {16'b0, exp_word});
        end
        full_frame("rnd_last");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
